// File: rtl/riscv_apu_responder_if.sv
// APU request/response bundle between a core's APU master and the responder.
// Handshake: a request transfers in a cycle with apu_req_i && apu_gnt_o; a result
// transfers in a cycle with apu_valid_o && apu_ready_i, and is held stable until then.
interface riscv_apu_responder_if;
  logic        apu_req_i;
  logic        apu_gnt_o;
  logic        apu_ready_i;
  logic [31:0] apu_operands_0_i;
  logic [31:0] apu_operands_1_i;
  logic [31:0] apu_operands_2_i;
  logic [5:0]  apu_op_i;
  logic        apu_type_i;
  logic [14:0] apu_flags_i;
  logic        apu_valid_o;
  logic [31:0] apu_result_o;
  logic [4:0]  apu_flags_o;

  modport master (
    output apu_req_i, apu_ready_i, apu_operands_0_i, apu_operands_1_i,
           apu_operands_2_i, apu_op_i, apu_type_i, apu_flags_i,
    input  apu_gnt_o, apu_valid_o, apu_result_o, apu_flags_o
  );

  modport slave (
    input  apu_req_i, apu_ready_i, apu_operands_0_i, apu_operands_1_i,
           apu_operands_2_i, apu_op_i, apu_type_i, apu_flags_i,
    output apu_gnt_o, apu_valid_o, apu_result_o, apu_flags_o
  );
endinterface

// File: rtl/riscv_apu_responder.sv
// Single-outstanding APU responder: fixed-latency integer ALU behind a req/gnt, valid/ready handshake.
// Define APU_RESPONDER_MAC_EN to compile in the multiply-accumulate op (op 7).
module riscv_apu_responder #(
  parameter int unsigned LATENCY = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  riscv_apu_responder_if.slave        apu,
  output logic                        busy_o,
  output logic [1:0]                  dbg_state_o,
  output logic [14:0]                 dbg_req_flags_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rflags_q, rflags_d;
  logic [31:0] a_q, b_q, c_q;
  logic [5:0]  op_q;
  logic        type_q;
  logic [14:0] req_flags_q;
  logic        grant;

  // In IDLE the ALU looks at the live request so LATENCY==1 can finish at grant.
  logic [31:0] alu_a, alu_b, alu_c;
  logic [5:0]  alu_op;
  logic        alu_type;

  always_comb begin
    alu_a    = a_q;
    alu_b    = b_q;
    alu_c    = c_q;
    alu_op   = op_q;
    alu_type = type_q;
    if (state_q == IDLE) begin
      alu_a    = apu.apu_operands_0_i;
      alu_b    = apu.apu_operands_1_i;
      alu_c    = apu.apu_operands_2_i;
      alu_op   = apu.apu_op_i;
      alu_type = apu.apu_type_i;
    end
  end

  logic [32:0] add_w;
  logic [31:0] mul_w;
  assign add_w = {1'b0, alu_a} + {1'b0, alu_b};
  assign mul_w = alu_a * alu_b;

`ifdef APU_RESPONDER_MAC_EN
  logic [31:0] mac_w;
  assign mac_w = mul_w + alu_c;
`else
  logic unused_op_c;
  assign unused_op_c = ^alu_c;
`endif

  logic [31:0] alu_res;
  logic [4:0]  alu_flags;
  logic        alu_carry;
  logic        alu_inv;

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    alu_carry = 1'b0;
    alu_inv   = 1'b0;
    if (alu_type) begin
      alu_inv = 1'b1;
    end else begin
      case (alu_op)
        6'd0: begin
          alu_res   = add_w[31:0];
          alu_carry = add_w[32];
        end
        6'd1: begin
          alu_res   = alu_a - alu_b;
          alu_carry = (alu_a < alu_b);
        end
        6'd2: alu_res = alu_a & alu_b;
        6'd3: alu_res = alu_a | alu_b;
        6'd4: alu_res = alu_a ^ alu_b;
        6'd5: alu_res = alu_a << alu_b[4:0];
        6'd6: alu_res = mul_w;
`ifdef APU_RESPONDER_MAC_EN
        6'd7: alu_res = mac_w;
`else
        6'd7: alu_inv = 1'b1;
`endif
        default: alu_inv = 1'b1;
      endcase
    end
    // Invalid requests report only the invalid flag, not the zero flag.
    if (alu_inv) begin
      alu_res   = '0;
      alu_flags = 5'b01000;
    end else begin
      alu_flags = {2'b00, alu_carry, alu_res[31], (alu_res == 32'd0)};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rflags_d = rflags_q;
    grant    = 1'b0;
    case (state_q)
      IDLE: begin
        grant = apu.apu_req_i && !rst_i;
        if (grant) begin
          if (LATENCY == 1) begin
            result_d = alu_res;
            rflags_d = alu_flags;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          result_d = alu_res;
          rflags_d = alu_flags;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (apu.apu_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rflags_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rflags_q <= rflags_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      op_q        <= '0;
      type_q      <= 1'b0;
      req_flags_q <= '0;
    end else if (grant) begin
      a_q         <= apu.apu_operands_0_i;
      b_q         <= apu.apu_operands_1_i;
      c_q         <= apu.apu_operands_2_i;
      op_q        <= apu.apu_op_i;
      type_q      <= apu.apu_type_i;
      req_flags_q <= apu.apu_flags_i;
    end
  end

  assign apu.apu_gnt_o    = grant;
  assign apu.apu_valid_o  = (state_q == DONE);
  assign apu.apu_result_o = result_q;
  assign apu.apu_flags_o  = rflags_q;
  assign busy_o           = (state_q != IDLE);
  assign dbg_state_o      = state_q;
  assign dbg_req_flags_o  = req_flags_q;

endmodule

// File: tb/tb_riscv_apu_responder.sv
// Directed + random bench for riscv_apu_responder at LATENCY 3 (dut_a) and LATENCY 1 (dut_b).
module tb_riscv_apu_responder;
  localparam int W     = 37;
  localparam int LAT_A = 3;

  logic clk;
  logic rst;
  logic busy_a, busy_b;
  logic [1:0]  st_a, st_b;
  logic [14:0] rf_a, rf_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qb[$];

  riscv_apu_responder_if ifa ();
  riscv_apu_responder_if ifb ();

  riscv_apu_responder #(.LATENCY(LAT_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .apu(ifa),
    .busy_o(busy_a), .dbg_state_o(st_a), .dbg_req_flags_o(rf_a)
  );

  riscv_apu_responder #(.LATENCY(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .apu(ifb),
    .busy_o(busy_b), .dbg_state_o(st_b), .dbg_req_flags_o(rf_b)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    n_errors++;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [5:0] op, input logic t,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    logic [63:0] wide;
    logic [31:0] r;
    logic        cy;
    logic        inv;
    wide = '0;
    r    = '0;
    cy   = 1'b0;
    inv  = t || (op > 6'd7);
`ifndef APU_RESPONDER_MAC_EN
    if (op == 6'd7) inv = 1'b1;
`endif
    case (op)
      6'd0: begin wide = {32'd0, a} + {32'd0, b}; r = wide[31:0]; cy = wide[32]; end
      6'd1: begin wide = {32'd0, a} - {32'd0, b}; r = wide[31:0]; cy = wide[63]; end
      6'd2: r = a & b;
      6'd3: r = a | b;
      6'd4: r = a ^ b;
      6'd5: begin wide = {32'd0, a} << b[4:0]; r = wide[31:0]; end
      6'd6: begin wide = {32'd0, a} * {32'd0, b}; r = wide[31:0]; end
      6'd7: begin wide = {32'd0, a} * {32'd0, b} + {32'd0, c}; r = wide[31:0]; end
      default: r = '0;
    endcase
    if (inv) return {32'd0, 5'b01000};
    return {r, 2'b00, cy, r[31], (r == 32'd0)};
  endfunction

  // scoreboard monitors: pop on each result transfer, check hold while stalled
  logic        hold_a = 1'b0;
  logic [31:0] hres_a;
  logic [4:0]  hflg_a;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && ifa.apu_valid_o && ifa.apu_ready_i) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL a_unexpected_result: observed %0h expected no transfer", ifa.apu_result_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("a_sb_result", 64'(ifa.apu_result_o), 64'(e[36:5]));
        chk("a_sb_flags", 64'(ifa.apu_flags_o), 64'(e[4:0]));
      end
    end
    if (!rst && hold_a && ifa.apu_valid_o) begin
      chk("a_hold_result", 64'(ifa.apu_result_o), 64'(hres_a));
      chk("a_hold_flags", 64'(ifa.apu_flags_o), 64'(hflg_a));
    end
    hold_a = !rst && ifa.apu_valid_o && !ifa.apu_ready_i;
    hres_a = ifa.apu_result_o;
    hflg_a = ifa.apu_flags_o;
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && ifb.apu_valid_o && ifb.apu_ready_i) begin
      n_checks++;
      assert (exp_qb.size() != 0) else begin
        n_errors++;
        $error("FAIL b_unexpected_result: observed %0h expected no transfer", ifb.apu_result_o);
      end
      if (exp_qb.size() != 0) begin
        e = exp_qb.pop_front();
        chk("b_sb_result", 64'(ifb.apu_result_o), 64'(e[36:5]));
        chk("b_sb_flags", 64'(ifb.apu_flags_o), 64'(e[4:0]));
      end
    end
  end

  // driver tasks
  task automatic drive_a(input logic [5:0] op, input logic t, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
    ifa.apu_req_i        = 1'b1;
    ifa.apu_op_i         = op;
    ifa.apu_type_i       = t;
    ifa.apu_operands_0_i = a;
    ifa.apu_operands_1_i = b;
    ifa.apu_operands_2_i = c;
    ifa.apu_flags_i      = 15'($urandom_range(0, 32767));
  endtask

  task automatic do_op(input logic [5:0] op, input logic t, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input int delay);
    int k;
    int lat;
    @(posedge clk); #1;
    drive_a(op, t, a, b, c);
    ifa.apu_ready_i = (delay == 0);
    #1;
    k = 0;
    while (!ifa.apu_gnt_o && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    chk("op_gnt_wait", 64'(k), 64'(0));
    exp_q.push_back(model(op, t, a, b, c));
    lat = 0;
    do begin
      @(posedge clk); #1;
      ifa.apu_req_i = 1'b0;
      #1;
      lat++;
    end while (!ifa.apu_valid_o && lat < 20);
    chk("op_latency", 64'(lat), 64'(LAT_A));
    for (int i = 1; i <= delay; i++) begin
      @(posedge clk); #1;
      ifa.apu_ready_i = (i == delay);
      #1;
      chk("op_stall_valid", 64'(ifa.apu_valid_o), 64'(1));
    end
    @(posedge clk); #2;
    chk("op_after_xfer_valid", 64'(ifa.apu_valid_o), 64'(0));
    chk("op_after_xfer_busy", 64'(busy_a), 64'(0));
  endtask

  initial begin
    logic [W-1:0] e;
    rst = 1'b1;
    drive_a(6'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    ifa.apu_ready_i      = 1'b1;
    ifb.apu_req_i        = 1'b0;
    ifb.apu_ready_i      = 1'b1;
    ifb.apu_op_i         = '0;
    ifb.apu_type_i       = 1'b0;
    ifb.apu_operands_0_i = '0;
    ifb.apu_operands_1_i = '0;
    ifb.apu_operands_2_i = '0;
    ifb.apu_flags_i      = '0;

    // reset state, with a request pending
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 64'(ifa.apu_gnt_o), 64'(0));
    chk("rst_valid", 64'(ifa.apu_valid_o), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_result", 64'(ifa.apu_result_o), 64'(0));
    chk("rst_flags", 64'(ifa.apu_flags_o), 64'(0));
    chk("rst_state", 64'(st_a), 64'(0));

    // ADD overflow, granted in the first cycle out of reset
    @(posedge clk); #1;
    rst = 1'b0;
    drive_a(6'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    ifa.apu_flags_i = 15'h5A5A;
    #1;
    chk("add_gnt_c0", 64'(ifa.apu_gnt_o), 64'(1));
    exp_q.push_back(model(6'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0));
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      ifa.apu_req_i = 1'b0;
      #1;
      chk("add_valid_timing", 64'(ifa.apu_valid_o), 64'(cyc == 3));
      if (cyc == 1) chk("add_req_flags", 64'(rf_a), 64'(15'h5A5A));
      if (cyc == 3) begin
        chk("add_result", 64'(ifa.apu_result_o), 64'(0));
        chk("add_flags", 64'(ifa.apu_flags_o), 64'(5'b00101));
      end
      if (cyc == 4) chk("add_idle", 64'(st_a), 64'(0));
    end

    // SUB with ready held low for 5 valid cycles; requests meanwhile are ignored
    @(posedge clk); #1;
    drive_a(6'd1, 1'b0, 32'd1, 32'd2, 32'd0);
    ifa.apu_ready_i = 1'b0;
    #1;
    chk("sub_gnt", 64'(ifa.apu_gnt_o), 64'(1));
    exp_q.push_back(model(6'd1, 1'b0, 32'd1, 32'd2, 32'd0));
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk); #1;
      ifa.apu_req_i   = (cyc >= 4 && cyc <= 6);
      ifa.apu_ready_i = (cyc >= 8);
      #1;
      chk("sub_valid", 64'(ifa.apu_valid_o), 64'(cyc >= 3 && cyc <= 8));
      chk("sub_no_gnt", 64'(ifa.apu_gnt_o), 64'(0));
      if (cyc >= 3 && cyc <= 8) begin
        chk("sub_result", 64'(ifa.apu_result_o), 64'(32'hFFFF_FFFF));
        chk("sub_flags", 64'(ifa.apu_flags_o), 64'(5'b00110));
      end
    end

    // back-to-back with the request held high
    @(posedge clk); #1;
    drive_a(6'd2, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    ifa.apu_ready_i = 1'b1;
    #1;
    chk("b2b_gnt0", 64'(ifa.apu_gnt_o), 64'(1));
    exp_q.push_back(model(6'd2, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0));
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) drive_a(6'd3, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'd0);
      ifa.apu_req_i = (cyc <= 4);
      #1;
      chk("b2b_gnt", 64'(ifa.apu_gnt_o), 64'(cyc == 4));
      chk("b2b_valid", 64'(ifa.apu_valid_o), 64'(cyc == 3 || cyc == 7));
      if (cyc == 4) exp_q.push_back(model(6'd3, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'd0));
    end
    chk("b2b_or_result", 64'(ifa.apu_result_o), 64'(32'h1234_5678));

    // MAC, invalid ops and a few directed ops; outputs hold after transfer
    do_op(6'd7, 1'b0, 32'd3, 32'd4, 32'd5, 1);
`ifdef APU_RESPONDER_MAC_EN
    chk("mac_result", 64'(ifa.apu_result_o), 64'(17));
    chk("mac_flags", 64'(ifa.apu_flags_o), 64'(0));
`else
    chk("mac_result", 64'(ifa.apu_result_o), 64'(0));
    chk("mac_flags", 64'(ifa.apu_flags_o), 64'(5'b01000));
`endif
    do_op(6'd5, 1'b0, 32'd1, 32'd33, 32'd0, 0);
    chk("sll_result", 64'(ifa.apu_result_o), 64'(2));
    do_op(6'd9, 1'b0, 32'd7, 32'd8, 32'd0, 0);
    chk("op9_result", 64'(ifa.apu_result_o), 64'(0));
    chk("op9_flags", 64'(ifa.apu_flags_o), 64'(5'b01000));
    do_op(6'd0, 1'b1, 32'd5, 32'd6, 32'd0, 2);
    chk("type1_flags", 64'(ifa.apu_flags_o), 64'(5'b01000));
    do_op(6'd6, 1'b0, 32'd7, 32'd9, 32'd0, 0);
    chk("mul_result", 64'(ifa.apu_result_o), 64'(63));

    // random ops with random ready stalls
    for (int i = 0; i < 12; i++) begin
      do_op(6'($urandom_range(0, 9)), ($urandom_range(0, 7) == 0), $urandom, $urandom,
            $urandom, int'($urandom_range(0, 3)));
    end

    // reset while BUSY discards the op; new request granted right after release
    @(posedge clk); #1;
    drive_a(6'd0, 1'b0, 32'd10, 32'd20, 32'd0);
    ifa.apu_ready_i = 1'b1;
    #1;
    chk("rb_gnt", 64'(ifa.apu_gnt_o), 64'(1));
    @(posedge clk); #1;
    ifa.apu_req_i = 1'b0;
    #1;
    chk("rb_busy_before", 64'(busy_a), 64'(1));
    rst = 1'b1;
    ifa.apu_req_i = 1'b1;
    #1;
    chk("rb_busy", 64'(busy_a), 64'(0));
    chk("rb_valid", 64'(ifa.apu_valid_o), 64'(0));
    chk("rb_result", 64'(ifa.apu_result_o), 64'(0));
    chk("rb_flags", 64'(ifa.apu_flags_o), 64'(0));
    chk("rb_gnt_in_rst", 64'(ifa.apu_gnt_o), 64'(0));
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #2;
      chk("rb_valid_in_rst", 64'(ifa.apu_valid_o), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_a(6'd4, 1'b0, 32'hAAAA_0000, 32'h0F0F_0F0F, 32'd0);
    #1;
    chk("rb_gnt_after", 64'(ifa.apu_gnt_o), 64'(1));
    exp_q.push_back(model(6'd4, 1'b0, 32'hAAAA_0000, 32'h0F0F_0F0F, 32'd0));
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      ifa.apu_req_i = 1'b0;
      #1;
      chk("rb_valid_timing", 64'(ifa.apu_valid_o), 64'(cyc == 3));
    end

    // LATENCY=1 instance
    @(posedge clk); #1;
    ifb.apu_req_i        = 1'b1;
    ifb.apu_op_i         = 6'd6;
    ifb.apu_operands_0_i = 32'h0001_0000;
    ifb.apu_operands_1_i = 32'h0001_0000;
    #1;
    chk("l1_gnt", 64'(ifb.apu_gnt_o), 64'(1));
    exp_qb.push_back(model(6'd6, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0));
    @(posedge clk); #1;
    ifb.apu_op_i         = 6'd0;
    ifb.apu_operands_0_i = 32'd2;
    ifb.apu_operands_1_i = 32'd3;
    #1;
    chk("l1_valid", 64'(ifb.apu_valid_o), 64'(1));
    chk("l1_result", 64'(ifb.apu_result_o), 64'(0));
    chk("l1_flags", 64'(ifb.apu_flags_o), 64'(5'b00001));
    chk("l1_no_gnt_xfer", 64'(ifb.apu_gnt_o), 64'(0));
    @(posedge clk); #2;
    chk("l1_gnt2", 64'(ifb.apu_gnt_o), 64'(1));
    chk("l1_valid_gap", 64'(ifb.apu_valid_o), 64'(0));
    exp_qb.push_back(model(6'd0, 1'b0, 32'd2, 32'd3, 32'd0));
    @(posedge clk); #1;
    ifb.apu_req_i = 1'b0;
    #1;
    chk("l1_valid2", 64'(ifb.apu_valid_o), 64'(1));
    chk("l1_result2", 64'(ifb.apu_result_o), 64'(5));
    @(posedge clk); #2;
    chk("l1_idle", 64'(busy_b), 64'(0));

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain_a", 64'(exp_q.size()), 64'(0));
    chk("sb_drain_b", 64'(exp_qb.size()), 64'(0));
    e = '0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
